// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: opcodes, FSM states,
// byte-lane constants and opcode classification helpers.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane generator: opcode + address offset + store data ->
// bus byteenable, endian-swapped writedata and misalignment flag.
module mem_lane_gen
  import mips_mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misaligned
);

  always_comb begin
    byteenable = BE_NONE;
    misaligned = 1'b0;
    case (opcode)
      OP_LW, OP_SW: begin
        byteenable = BE_ALL;
        misaligned = (offset != 2'b00);
      end
      OP_LB, OP_LBU, OP_SB: byteenable = BE_B0 << offset;
      OP_LH, OP_LHU, OP_SH: begin
        byteenable = offset[1] ? BE_HI : BE_LO;
        misaligned = offset[0];
      end
      // LWL keeps lanes at and above the offset, LWR at and below it
      OP_LWL: byteenable = BE_ALL << offset;
      OP_LWR: byteenable = BE_ALL >> (2'd3 - offset);
      default: ;
    endcase
  end

  always_comb begin
    writedata = '0;
    case (opcode)
      OP_SW: writedata = {store_data[7:0], store_data[15:8], store_data[23:16], store_data[31:24]};
      OP_SH: writedata = {store_data[7:0], store_data[15:8], store_data[7:0], store_data[15:8]};
      OP_SB: writedata = {4{store_data[7:0]}};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one Avalon-style transaction per load/store, result
// handed to the load formatter with a done pulse. MEM_TIMEOUT_EN adds a stall abort.
module mem_access
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] eff_addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_byteenable
);

  logic [5:0]  opcode;
  logic        op_load;
  logic        op_valid;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic        lane_mis;

  state_t state;
  logic   mis_q;
  logic   load_q;
  logic   err_pending;

  logic unused_bits;

  assign opcode      = instruction[31:26];
  assign op_load     = is_load(opcode);
  assign op_valid    = op_load | is_store(opcode);
  assign unused_bits = ^instruction[25:0];

  mem_lane_gen u_lane_gen (
    .opcode     (opcode),
    .offset     (eff_addr[1:0]),
    .store_data (store_data),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .misaligned (lane_mis)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  // Misaligned requests still pass through BUS with no strobe so every
  // request sees the same start-to-done latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      address        <= '0;
      byteenable     <= '0;
      writedata      <= '0;
      mem_data       <= '0;
      mem_byteenable <= '0;
      mis_q          <= 1'b0;
      load_q         <= 1'b0;
      err_pending    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            state       <= BUS;
            busy        <= 1'b1;
            address     <= {eff_addr[31:2], 2'b00};
            byteenable  <= lane_be;
            writedata   <= lane_wd;
            read        <= ~lane_mis & op_load;
            write       <= ~lane_mis & ~op_load;
            mis_q       <= lane_mis;
            load_q      <= op_load;
            err_pending <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        BUS: begin
          if (mis_q) begin
            state       <= DONE;
            err_pending <= 1'b1;
          end else if (!waitrequest) begin
            state          <= DONE;
            read           <= 1'b0;
            write          <= 1'b0;
            mem_byteenable <= byteenable;
            if (load_q) mem_data <= readdata;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state       <= DONE;
            read        <= 1'b0;
            write       <= 1'b0;
            err_pending <= 1'b1;
            mem_data    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= err_pending;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// transactions against a lane-table reference model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LWL = 6'b100010, LW = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101, LWR = 6'b100110;
  localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset, start, waitrequest;
  logic [31:0] instruction, eff_addr, store_data, readdata;
  logic        busy, done, err, read, write;
  logic [31:0] address, writedata, mem_data;
  logic [3:0]  byteenable, mem_byteenable;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem_data;
  logic [3:0]  m_mem_be;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction),
    .eff_addr(eff_addr), .store_data(store_data), .busy(busy), .done(done),
    .err(err), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .mem_data(mem_data), .mem_byteenable(mem_byteenable)
  );

  always #5 clk = ~clk;

  function automatic bit ref_is_load(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LWL) || (op == LW) ||
           (op == LBU) || (op == LHU) || (op == LWR);
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [1:0] off);
    logic [3:0] be;
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      if (op == LB || op == LBU || op == SB)      be[i] = (i == o);
      else if (op == LH || op == LHU || op == SH) be[i] = (i / 2 == o / 2);
      else if (op == LWL)                         be[i] = (i >= o);
      else if (op == LWR)                         be[i] = (i <= o);
      else if (op == LW || op == SW)              be[i] = 1'b1;
      else                                        be[i] = 1'b0;
    end
    return be;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [5:0] op, input logic [31:0] sd);
    logic [31:0] wd, t;
    int src;
    wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (op == SW)      src = 3 - i;
      else if (op == SH) src = (i % 2 == 1) ? 0 : 1;
      else               src = 0;
      t = sd >> (8 * src);
      if (op == SW || op == SH || op == SB) wd[8*i +: 8] = t[7:0];
    end
    return wd;
  endfunction

  function automatic bit ref_mis(input logic [5:0] op, input logic [1:0] off);
    if (op == LH || op == LHU || op == SH) return off[0];
    if (op == LW || op == SW) return off != 2'b00;
    return 1'b0;
  endfunction

  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input int waits, input bit stuck, input bit poke,
                         input logic [31:0] rdv, input string name);
    logic [3:0]  e_be;
    logic [31:0] e_wd, a1, wd1;
    logic [3:0]  be1;
    bit e_mis, ld, e_err, busy1, rd1, wr1, err_at_done;
    int exp_strobe, exp_done_k, strobe_cnt, done_cnt, done_k, both, unstable;
    e_be  = ref_be(op, addr[1:0]);
    e_wd  = ref_wd(op, sd);
    e_mis = ref_mis(op, addr[1:0]);
    ld    = ref_is_load(op);
    e_err = e_mis || stuck;
    exp_strobe = e_mis ? 0 : (stuck ? int'(TO) : waits + 1);
    exp_done_k = e_mis ? 3 : exp_strobe + 2;
    strobe_cnt = 0; done_cnt = 0; done_k = -1; both = 0; unstable = 0; err_at_done = 0;
    a1 = '0; wd1 = '0; be1 = '0; busy1 = 0; rd1 = 0; wr1 = 0;

    @(negedge clk);
    instruction = {op, 26'($urandom)};
    eff_addr    = addr;
    store_data  = sd;
    start       = 1'b1;
    waitrequest = 1'($urandom);
    readdata    = $urandom;
    for (int k = 1; k <= exp_done_k + 3; k++) begin
      @(negedge clk);
      start = poke && (k == 1);
      if (k == 1) begin
        a1 = address; be1 = byteenable; wd1 = writedata;
        busy1 = busy; rd1 = read; wr1 = write;
      end
      if (read || write) begin
        strobe_cnt++;
        if (address !== a1 || byteenable !== be1 || writedata !== wd1 || read !== rd1 || write !== wr1)
          unstable++;
      end
      if (read && write) both++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin done_k = k; err_at_done = err; end
      end
      waitrequest = stuck ? 1'b1 : (k <= waits);
      readdata    = (k == waits + 1) ? rdv : $urandom;
    end
    waitrequest = 1'b0;

    if (!e_mis) begin
      if (stuck) m_mem_data = '0;
      else if (ld) m_mem_data = rdv;
      if (!stuck) m_mem_be = e_be;
    end

    n_checks++; if (busy1 !== 1'b1) $display("FAIL %s busy got %b want 1", name, busy1); else n_pass++;
    n_checks++; if (rd1 !== (!e_mis && ld)) $display("FAIL %s read got %b want %b", name, rd1, !e_mis && ld); else n_pass++;
    n_checks++; if (wr1 !== (!e_mis && !ld)) $display("FAIL %s write got %b want %b", name, wr1, !e_mis && !ld); else n_pass++;
    n_checks++; if (strobe_cnt != exp_strobe) $display("FAIL %s strobe_cycles got %0d want %0d", name, strobe_cnt, exp_strobe); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); else n_pass++;
    n_checks++; if (done_k != exp_done_k) $display("FAIL %s done_cycle got %0d want %0d", name, done_k, exp_done_k); else n_pass++;
    n_checks++; if (err_at_done !== e_err) $display("FAIL %s err got %b want %b", name, err_at_done, e_err); else n_pass++;
    n_checks++; if (both != 0 || unstable != 0) $display("FAIL %s bus_stable got both=%0d unstable=%0d want 0/0", name, both, unstable); else n_pass++;
    if (!e_mis) begin
      n_checks++; if (a1 !== {addr[31:2], 2'b00}) $display("FAIL %s address got %h want %h", name, a1, {addr[31:2], 2'b00}); else n_pass++;
      n_checks++; if (be1 !== e_be) $display("FAIL %s byteenable got %b want %b", name, be1, e_be); else n_pass++;
      n_checks++; if (wd1 !== e_wd) $display("FAIL %s writedata got %h want %h", name, wd1, e_wd); else n_pass++;
    end
    n_checks++; if (mem_data !== m_mem_data) $display("FAIL %s mem_data got %h want %h", name, mem_data, m_mem_data); else n_pass++;
    n_checks++; if (mem_byteenable !== m_mem_be) $display("FAIL %s mem_byteenable got %b want %b", name, mem_byteenable, m_mem_be); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; waitrequest = 1'b0;
    instruction = '0; eff_addr = '0; store_data = '0; readdata = '0;
    m_mem_data = '0; m_mem_be = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, err, read, write} !== 5'b0) $display("FAIL reset ctrl got %b want 00000", {busy, done, err, read, write}); else n_pass++;
    n_checks++; if ({address, writedata, byteenable} !== '0) $display("FAIL reset bus got %h/%h/%b want 0", address, writedata, byteenable); else n_pass++;
    n_checks++; if ({mem_data, mem_byteenable} !== '0) $display("FAIL reset mem got %h/%b want 0", mem_data, mem_byteenable); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_lw_basic();
    run_txn(LW, 32'h0000_1000, $urandom, 0, 0, 0, 32'hAABB_CCDD, "lw_basic");
  endtask

  task automatic test_sh_store();
    run_txn(SH, 32'h0000_2002, 32'h0000_1234, 0, 0, 0, $urandom, "sh_store");
  endtask

  task automatic test_lb_wait();
    run_txn(LB, 32'h0000_3003, $urandom, 3, 0, 0, 32'h1122_3344, "lb_wait");
  endtask

  task automatic test_misaligned_busy();
    run_txn(LW, 32'h0000_4001, $urandom, 0, 0, 1, $urandom, "lw_misaligned_poke");
    run_txn(SH, 32'h0000_4003, $urandom, 0, 0, 0, $urandom, "sh_misaligned");
    run_txn(SW, 32'h0000_4008, 32'hDEAD_BEEF, 1, 0, 1, $urandom, "sw_poke");
  endtask

  task automatic test_lwl_lwr();
    run_txn(LWL, 32'h0000_5001, $urandom, 0, 0, 0, 32'h5555_0001, "lwl");
    run_txn(LWR, 32'h0000_5002, $urandom, 1, 0, 0, 32'h5555_0002, "lwr");
  endtask

  task automatic test_invalid_op();
    int act;
    act = 0;
    @(negedge clk);
    instruction = {6'b100111, 26'($urandom)}; eff_addr = 32'h0000_6000; start = 1'b1;
    @(negedge clk);
    instruction = {6'b101010, 26'($urandom)};
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || read || write) act++;
    end
    n_checks++; if (act != 0) $display("FAIL invalid_op activity got %0d want 0", act); else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    instruction = {LW, 26'd0}; eff_addr = 32'h0000_7000; start = 1'b1; waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (read !== 1'b1) $display("FAIL midbus read_before got %b want 1", read); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({read, write, busy} !== 3'b000) $display("FAIL midbus strobes_on_reset got %b want 000", {read, write, busy}); else n_pass++;
    @(negedge clk);
    reset = 1'b0; waitrequest = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    m_mem_data = '0; m_mem_be = '0;
    n_checks++; if (dcnt != 0) $display("FAIL midbus done_pulses got %0d want 0", dcnt); else n_pass++;
    n_checks++; if (mem_data !== m_mem_data) $display("FAIL midbus mem_data got %h want %h", mem_data, m_mem_data); else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW};
    for (int t = 0; t < 30; t++)
      run_txn(ops[$urandom_range(0, 9)], $urandom, $urandom, int'($urandom_range(0, 3)),
              0, bit'($urandom_range(0, 1)), $urandom, "random");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(LW, 32'h0000_8000, $urandom, 0, 1, 0, $urandom, "timeout");
  endtask
`else
  task automatic test_long_stall();
    run_txn(LW, 32'h0000_8000, $urandom, 12, 0, 0, 32'h0BAD_F00D, "long_stall");
  endtask
`endif

  initial begin
    test_reset();
    test_lw_basic();
    test_sh_store();
    test_lb_wait();
    test_misaligned_busy();
    test_lwl_lwr();
    test_invalid_op();
    test_reset_mid_bus();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
